fclass_pipe: RTL

FCLASS_PIPE -- requirements
Module: fclass_pipe

---
 rtl/fclass_pipe.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fclass_pipe.sv
// Two-stage floating-point classifier producing the one-hot class mask, with valid/ready flow control.
// Optional per-class saturating statistics counters are enabled by defining FCLASS_COUNT_EN.
module fclass_pipe #(
    parameter int XLEN = 64,
    parameter int FLEN = 64,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            InValid,
    output logic            InReady,
    input  logic [FLEN-1:0] X,
    input  logic [1:0]      Fmt,
    input  logic            Flush,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] ClassRes,
    input  logic [3:0]      CntSel,
    input  logic            CntClear,
    output logic [CNTW-1:0] CntVal
);

    logic        s1Valid, s2Valid;
    logic        s1Sign, s1ExpOnes, s1ExpZero, s1FracZero, s1FracMsb, s1BoxFail;
    logic        s2Load, s1Advance, accept;
    logic [63:0] xw;
    logic        box32Ok, box16Ok;
    logic        dSign, dExpOnes, dExpZero, dFracZero, dFracMsb, dBoxFail;
    logic [9:0]  classNext;

    assign OutValid  = s2Valid;
    assign s2Load    = ~s2Valid | OutReady;
    assign s1Advance = s1Valid & s2Load;
    assign InReady   = ~reset & ~Flush & (~s1Valid | s1Advance);
    assign accept    = InValid & InReady;

    // A narrower operand is only legal when every bit above it is one (NaN boxing).
    assign xw      = 64'(X);
    assign box32Ok = &(X | FLEN'(32'hFFFF_FFFF));
    assign box16Ok = &(X | FLEN'(16'hFFFF));

    always_comb begin
        dSign     = 1'b0;
        dExpOnes  = 1'b0;
        dExpZero  = 1'b0;
        dFracZero = 1'b0;
        dFracMsb  = 1'b0;
        dBoxFail  = 1'b1;
        case (Fmt)
            2'b00: begin
                dSign     = xw[31];
                dExpOnes  = &xw[30:23];
                dExpZero  = ~|xw[30:23];
                dFracZero = ~|xw[22:0];
                dFracMsb  = xw[22];
                dBoxFail  = ~box32Ok;
            end
            2'b01: begin
                dSign     = xw[63];
                dExpOnes  = &xw[62:52];
                dExpZero  = ~|xw[62:52];
                dFracZero = ~|xw[51:0];
                dFracMsb  = xw[51];
                dBoxFail  = (FLEN != 64);
            end
            2'b10: begin
                dSign     = xw[15];
                dExpOnes  = &xw[14:10];
                dExpZero  = ~|xw[14:10];
                dFracZero = ~|xw[9:0];
                dFracMsb  = xw[9];
                dBoxFail  = ~box16Ok;
            end
            default: dBoxFail = 1'b1;
        endcase
    end

    // Stage 1 captures the unpacked field flags of each accepted operand.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid    <= 1'b0;
            s1Sign     <= 1'b0;
            s1ExpOnes  <= 1'b0;
            s1ExpZero  <= 1'b0;
            s1FracZero <= 1'b0;
            s1FracMsb  <= 1'b0;
            s1BoxFail  <= 1'b0;
        end else if (Flush) begin
            s1Valid <= 1'b0;
        end else if (accept) begin
            s1Valid    <= 1'b1;
            s1Sign     <= dSign;
            s1ExpOnes  <= dExpOnes;
            s1ExpZero  <= dExpZero;
            s1FracZero <= dFracZero;
            s1FracMsb  <= dFracMsb;
            s1BoxFail  <= dBoxFail;
        end else if (s1Advance) begin
            s1Valid <= 1'b0;
        end
    end

    // Bad boxing and unsupported formats both collapse to the canonical quiet NaN.
    always_comb begin
        classNext = 10'h000;
        if (s1BoxFail) begin
            classNext = 10'h200;
        end else if (s1ExpOnes) begin
            if (s1FracZero)     classNext = s1Sign ? 10'h001 : 10'h080;
            else if (s1FracMsb) classNext = 10'h200;
            else                classNext = 10'h100;
        end else if (s1ExpZero) begin
            if (s1FracZero) classNext = s1Sign ? 10'h008 : 10'h010;
            else            classNext = s1Sign ? 10'h004 : 10'h020;
        end else begin
            classNext = s1Sign ? 10'h002 : 10'h040;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2Valid  <= 1'b0;
            ClassRes <= '0;
        end else if (Flush) begin
            s2Valid <= 1'b0;
        end else if (s2Load) begin
            s2Valid <= s1Valid;
            if (s1Valid) ClassRes <= XLEN'(classNext);
        end
    end

`ifdef FCLASS_COUNT_EN
    logic [CNTW-1:0] cnt [10];

    // Clearing beats counting; a full counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || CntClear) begin
            for (int k = 0; k < 10; k++) cnt[k] <= '0;
        end else if (s2Valid && OutReady) begin
            for (int k = 0; k < 10; k++) begin
                if (ClassRes[k] && !(&cnt[k])) cnt[k] <= cnt[k] + CNTW'(1);
            end
        end
    end

    always_comb begin
        CntVal = '0;
        if (CntSel < 4'd10) CntVal = cnt[CntSel];
    end
`else
    logic unusedCnt;
    assign unusedCnt = ^{CntSel, CntClear};
    assign CntVal    = '0;
`endif

endmodule
